// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath types and register-file constants
//
// Purpose: common constants and typedefs for the register file and its scoreboard.
//   REG_COUNT  number of architectural registers (fixed power of two)
//   REG_SELW   register index width, log2(REG_COUNT)
//   WORD_WIDTH default datapath word width
//   reg_sel_t  register index type
//   word_t     datapath word type
//   sel_match  strobe-qualified index compare used by bypass/busy/scoreboard logic
package cpu_pkg;

  localparam int REG_COUNT  = 16;
  localparam int REG_SELW   = 4;
  localparam int WORD_WIDTH = 32;

  typedef logic [REG_SELW-1:0]   reg_sel_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  // True when a strobed port targets the given index.
  function automatic logic sel_match(input logic en, input reg_sel_t a, input reg_sel_t b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending scoreboard with WAW detection
//
// Purpose: tracks which registers have an issued but not yet written-back producer.
// Optional feature macro: REGFILE_R0_ZERO_EN (register 0 is hardwired zero, never pending).
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   iss_en, iss_sel       issue strobe and destination index (marks pending)
//   wr_en, wr_sel         writeback strobe and index (clears pending)
//   rd_a_sel, rd_b_sel    read port indices for busy lookup
//   pending               registered scoreboard vector, bit i = register i busy
//   rd_a_busy, rd_b_busy  combinational busy per read port, masked by same-cycle writeback
//   waw_err               registered one-cycle pulse: issue to a still-pending register
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int COUNT = REG_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en,
  input  logic [3:0]       iss_sel,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [3:0]       rd_a_sel,
  input  logic [3:0]       rd_b_sel,
  output logic [COUNT-1:0] pending,
  output logic             rd_a_busy,
  output logic             rd_b_busy,
  output logic             waw_err
);

  logic [COUNT-1:0] pending_q;
  logic [COUNT-1:0] pending_d;
  logic             waw_err_q;
  logic             waw_err_d;
  logic             iss_mark;
  logic             wr_hits_iss;

  always_comb begin
    iss_mark = iss_en;
`ifdef REGFILE_R0_ZERO_EN
    // Register 0 never has a producer to wait for.
    if (iss_sel == '0) begin
      iss_mark = 1'b0;
    end
`endif
    wr_hits_iss = sel_match(wr_en, wr_sel, iss_sel);

    pending_d = pending_q;
    if (wr_en) begin
      pending_d[wr_sel] = 1'b0;
    end
    // Applied after the clear so a new producer supersedes the one writing back.
    if (iss_mark) begin
      pending_d[iss_sel] = 1'b1;
    end

    // A writeback landing on the same index in the same cycle retires the old
    // producer, so the new issue is not a hazard.
    waw_err_d = iss_mark && pending_q[iss_sel] && !wr_hits_iss;
  end

  always_comb begin
    rd_a_busy = pending_q[rd_a_sel] && !sel_match(wr_en, wr_sel, rd_a_sel);
    rd_b_busy = pending_q[rd_b_sel] && !sel_match(wr_en, wr_sel, rd_b_sel);
`ifdef REGFILE_R0_ZERO_EN
    if (rd_a_sel == '0) begin
      rd_a_busy = 1'b0;
    end
    if (rd_b_sel == '0) begin
      rd_b_busy = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      waw_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      waw_err_q <= waw_err_d;
    end
  end

  assign pending = pending_q;
  assign waw_err = waw_err_q;

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 16-entry register file with write bypass and pending scoreboard
//
// Purpose: CPU general-purpose registers, two combinational read ports with
// writeback bypass, one synchronous write port, and an issue/writeback scoreboard.
// Optional feature macro: REGFILE_R0_ZERO_EN (register 0 reads zero, writes discarded).
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   rd_a_sel, rd_a_data   read port A index and data (combinational, bypassed)
//   rd_a_busy             register at rd_a_sel has an outstanding write
//   rd_b_sel, rd_b_data   read port B index and data (combinational, bypassed)
//   rd_b_busy             register at rd_b_sel has an outstanding write
//   wr_en, wr_sel, wr_data writeback strobe, index and data
//   iss_en, iss_sel       issue strobe and destination index
//   pending               registered scoreboard vector
//   waw_err               registered one-cycle WAW pulse
module regfile
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int COUNT = REG_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rd_a_sel,
  output logic [WIDTH-1:0] rd_a_data,
  output logic             rd_a_busy,
  input  logic [3:0]       rd_b_sel,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             rd_b_busy,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [3:0]       iss_sel,
  output logic [COUNT-1:0] pending,
  output logic             waw_err
);

  logic [WIDTH-1:0] regs_q [COUNT];
  logic [WIDTH-1:0] regs_d [COUNT];
  logic             wr_store;

  // Storage update
  always_comb begin
    wr_store = wr_en;
`ifdef REGFILE_R0_ZERO_EN
    if (wr_sel == '0) begin
      wr_store = 1'b0;
    end
`endif
    for (int i = 0; i < COUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_store) begin
      regs_d[wr_sel] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: each port bypasses the in-flight writeback independently.
  always_comb begin
    rd_a_data = regs_q[rd_a_sel];
    if (sel_match(wr_en, wr_sel, rd_a_sel)) begin
      rd_a_data = wr_data;
    end
    rd_b_data = regs_q[rd_b_sel];
    if (sel_match(wr_en, wr_sel, rd_b_sel)) begin
      rd_b_data = wr_data;
    end
`ifdef REGFILE_R0_ZERO_EN
    // Register 0 is constant zero, so a writeback to it must not bypass either.
    if (rd_a_sel == '0) begin
      rd_a_data = '0;
    end
    if (rd_b_sel == '0) begin
      rd_b_data = '0;
    end
`endif
  end

  regfile_scoreboard #(
    .COUNT (COUNT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_en    (iss_en),
    .iss_sel   (iss_sel),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .rd_a_sel  (rd_a_sel),
    .rd_b_sel  (rd_b_sel),
    .pending   (pending),
    .rd_a_busy (rd_a_busy),
    .rd_b_busy (rd_b_busy),
    .waw_err   (waw_err)
  );

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking scoreboard bench for regfile
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_a_sel;
  logic [31:0] rd_a_data;
  logic        rd_a_busy;
  logic [3:0]  rd_b_sel;
  logic [31:0] rd_b_data;
  logic        rd_b_busy;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [3:0]  iss_sel;
  logic [15:0] pending;
  logic        waw_err;

  always #5 clk = ~clk;

  regfile #(.WIDTH(32), .COUNT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_a_sel  (rd_a_sel),
    .rd_a_data (rd_a_data),
    .rd_a_busy (rd_a_busy),
    .rd_b_sel  (rd_b_sel),
    .rd_b_data (rd_b_data),
    .rd_b_busy (rd_b_busy),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_sel   (iss_sel),
    .pending   (pending),
    .waw_err   (waw_err)
  );

  localparam logic [2:0] K_RDA = 3'd0, K_RDB = 3'd1, K_BSA = 3'd2,
                         K_BSB = 3'd3, K_PND = 3'd4, K_WAW = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference state
  logic [31:0] m_regs [16];
  logic [15:0] m_pend;
  logic        m_waw;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_RDA:   return "rd_a_data";
      K_RDB:   return "rd_b_data";
      K_BSA:   return "rd_a_busy";
      K_BSB:   return "rd_b_busy";
      K_PND:   return "pending";
      default: return "waw_err";
    endcase
  endfunction

  function automatic logic [31:0] observe(input logic [2:0] k);
    case (k)
      K_RDA:   return rd_a_data;
      K_RDB:   return rd_b_data;
      K_BSA:   return {31'b0, rd_a_busy};
      K_BSB:   return {31'b0, rd_b_busy};
      K_PND:   return {16'b0, pending};
      default: return {31'b0, waw_err};
    endcase
  endfunction

  task automatic push(input logic [2:0] k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(kname(e.kind), observe(e.kind), e.val);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] sel);
    if (R0Z && sel == 4'd0) return 32'h0;
    if (wr_en && wr_sel == sel) return wr_data;
    return m_regs[sel];
  endfunction

  function automatic logic m_busy(input logic [3:0] sel);
    if (R0Z && sel == 4'd0) return 1'b0;
    return m_pend[sel] && !(wr_en && wr_sel == sel);
  endfunction

  task automatic push_model();
    push(K_RDA, m_rd(rd_a_sel));
    push(K_RDB, m_rd(rd_b_sel));
    push(K_BSA, {31'b0, m_busy(rd_a_sel)});
    push(K_BSB, {31'b0, m_busy(rd_b_sel)});
    push(K_PND, {16'b0, m_pend});
    push(K_WAW, {31'b0, m_waw});
  endtask

  task automatic model_update();
    logic iss_ok;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_pend = 16'h0;
      m_waw  = 1'b0;
    end else begin
      iss_ok = iss_en && !(R0Z && iss_sel == 4'd0);
      m_waw  = iss_ok && m_pend[iss_sel] && !(wr_en && wr_sel == iss_sel);
      if (wr_en && !(R0Z && wr_sel == 4'd0)) m_regs[wr_sel] = wr_data;
      if (wr_en) m_pend[wr_sel] = 1'b0;
      if (iss_ok) m_pend[iss_sel] = 1'b1;
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
  task automatic cyc(input logic r, input logic we, input logic [3:0] ws, input logic [31:0] wd,
                     input logic ie, input logic [3:0] is, input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    rst = r; wr_en = we; wr_sel = ws; wr_data = wd;
    iss_en = ie; iss_sel = is; rd_a_sel = ra; rd_b_sel = rb;
    #1;
  endtask

  // Compare everything queued for this cycle, then advance the clock and the model.
  task automatic fin();
    push_model();
    drain();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 32'hx;
    m_pend = 16'hx;
    m_waw  = 1'bx;

    // Reset, then every index on both ports reads zero and nothing is busy.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    @(posedge clk);
    model_update();
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 0, i[3:0], 4'(15 - i));
      push(K_RDA, 32'h0); push(K_RDB, 32'h0); push(K_PND, 32'h0);
      push(K_BSA, 32'h0); push(K_WAW, 32'h0);
      fin();
    end

    // Same-cycle bypass, then readback from storage.
    cyc(0, 1, 4'd5, 32'hDEADBEEF, 0, 0, 4'd5, 4'd5);
    push(K_RDA, 32'hDEADBEEF); push(K_RDB, 32'hDEADBEEF);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 4'd5, 4'd1);
    push(K_RDA, 32'hDEADBEEF);
    fin();

    // Issue marks pending; writeback clears busy immediately and pending next cycle.
    cyc(0, 0, 0, 0, 1, 4'd3, 0, 4'd3);
    push(K_BSB, 32'h0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd3);
    push(K_PND, 32'h0008); push(K_BSB, 32'h1);
    fin();
    cyc(0, 1, 4'd3, 32'hA5A5_0003, 0, 0, 0, 4'd3);
    push(K_BSB, 32'h0); push(K_RDB, 32'hA5A5_0003);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd3);
    push(K_PND, 32'h0000);
    fin();

    // Issue+writeback same index: set wins and no WAW; bare re-issue pulses WAW once.
    cyc(0, 0, 0, 0, 1, 4'd7, 0, 0);
    fin();
    cyc(0, 1, 4'd7, 32'h7777_7777, 1, 4'd7, 0, 0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 4'd7, 0);
    push(K_PND, 32'h0080); push(K_WAW, 32'h0); push(K_BSA, 32'h1);
    fin();
    cyc(0, 0, 0, 0, 1, 4'd7, 0, 0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    push(K_WAW, 32'h1); push(K_PND, 32'h0080);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    push(K_WAW, 32'h0);
    fin();

    // Writeback to a non-pending register leaves pending clear.
    cyc(0, 1, 4'd7, 32'h0, 0, 0, 0, 0);
    fin();
    cyc(0, 1, 4'd11, 32'hCAFE_F00D, 0, 0, 0, 0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 4'd11, 0);
    push(K_PND, 32'h0); push(K_RDA, 32'hCAFE_F00D);
    fin();

    // Reset mid-operation discards the write on the reset edge and all pending.
    cyc(0, 1, 4'd9, 32'h12345678, 1, 4'd2, 0, 0);
    fin();
    cyc(1, 1, 4'd9, 32'hFFFFFFFF, 1, 4'd4, 0, 0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 4'd9, 4'd2);
    push(K_RDA, 32'h0); push(K_PND, 32'h0); push(K_BSB, 32'h0);
    fin();

`ifdef REGFILE_R0_ZERO_EN
    cyc(0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 4'd0, 4'd0);
    push(K_RDA, 32'h0); push(K_RDB, 32'h0);
    fin();
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0);
    push(K_RDA, 32'h0); push(K_PND, 32'h0); push(K_WAW, 32'h0); push(K_BSA, 32'h0);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    push(K_WAW, 32'h0); push(K_PND, 32'h0);
    fin();
`else
    cyc(0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 4'd0, 4'd0);
    push(K_RDA, 32'hFFFFFFFF);
    fin();
    cyc(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    push(K_RDA, 32'hFFFFFFFF); push(K_PND, 32'h0001); push(K_BSA, 32'h1);
    fin();
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 40) == 0), 1'($urandom), 4'($urandom), $urandom,
          1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      fin();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file for the CPU datapath: 16 entries x WIDTH bits, two combinational read ports, one synchronous write port.
- Sits downstream of decode and upstream of the ALU operand muxes; writeback drives the write port.
- Contains a per-register pending scoreboard. Issue marks a destination busy; writeback clears it. Decode uses the busy flags to stall.

Parameters:
- WIDTH, 32, data width of each register.
- COUNT, 16, number of registers; fixed power of two; select width SELW = log2(COUNT) = 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- rd_a_sel  input  4  read port A register index
- rd_a_data  output  WIDTH  read port A data (combinational)
- rd_a_busy  output  1  register at rd_a_sel has an outstanding write
- rd_b_sel  input  4  read port B register index
- rd_b_data  output  WIDTH  read port B data (combinational)
- rd_b_busy  output  1  register at rd_b_sel has an outstanding write
- wr_en  input  1  writeback strobe
- wr_sel  input  4  writeback register index
- wr_data  input  WIDTH  writeback data
- iss_en  input  1  issue strobe; marks iss_sel pending
- iss_sel  input  4  issued destination index
- pending  output  COUNT  registered scoreboard vector, bit i = reg i busy
- waw_err  output  1  registered one-cycle pulse: issue hit an already-pending register not cleared that cycle

Behaviour:
- Reset is synchronous. On a clk edge with rst=1:
  - all registers become 0; pending becomes 0; waw_err becomes 0.
  - wr_en and iss_en are ignored that cycle.
  - Reset mid-operation discards all outstanding writes.
- Write: on a clk edge with wr_en=1, reg[wr_sel] <= wr_data. Latency is 1 cycle to storage.
- Read: rd_x_data = reg[rd_x_sel] combinationally.
  - Bypass: if wr_en=1 and wr_sel==rd_x_sel, rd_x_data = wr_data in the same cycle.
  - Both ports may read the same index; each port bypasses independently.
- Scoreboard next-state, per bit i:
  - set if iss_en and iss_sel==i;
  - else clear if wr_en and wr_sel==i;
  - else hold.
  - Simultaneous issue and writeback to the same index: set wins, because a new producer supersedes the old one.
- Busy: rd_x_busy = pending[rd_x_sel] AND NOT (wr_en AND wr_sel==rd_x_sel).
  - A register being written this cycle is not busy, since its data is bypassed.
  - Same-cycle issue does not raise busy until the next cycle.
- Writeback to a non-pending register is legal: data is written and pending is unchanged (stays 0).
- waw_err is registered: waw_err <= iss_en AND pending[iss_sel] AND NOT (wr_en AND wr_sel==iss_sel).
  - The offending issue still takes effect; the bit stays set.
- Select inputs are full-range 4-bit values, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN
- Defined:
  - reg 0 reads as 0 on both ports, with no bypass for index 0.
  - Writes to index 0 are discarded.
  - pending[0] is never set; issue to 0 never raises waw_err.
  - rd_x_busy is 0 when rd_x_sel==0.
- Undefined: reg 0 behaves as an ordinary register.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_COUNT=16 and REG_SELW=4;
  - a reg_sel_t typedef (4-bit index) and a word_t typedef (WIDTH default 32).
- One natural sub-module: regfile_scoreboard.
  - Inputs: clk, rst, iss_en/iss_sel, wr_en/wr_sel, two read selects.
  - Outputs: pending, rd_a_busy, rd_b_busy, waw_err.
  - The storage array and bypass muxing stay in regfile.

Test Plan:
- Reset then read all 16 indices on both ports -> every rd_x_data=0, pending=16'h0000, busy=0, waw_err=0.
- wr_en=1 wr_sel=5 wr_data=32'hDEADBEEF with rd_a_sel=5 in the same cycle -> rd_a_data=32'hDEADBEEF that cycle (bypass); next cycle, wr_en=0 -> still 32'hDEADBEEF from storage.
- iss_en=1 iss_sel=3 -> next cycle pending=16'h0008 and rd_b_busy=1 at rd_b_sel=3. Then wr_en=1 wr_sel=3 -> rd_b_busy=0 that cycle, and next cycle pending=16'h0000.
- Same cycle iss_en=1 iss_sel=7 and wr_en=1 wr_sel=7 with pending[7]=1 -> pending[7] stays 1 and waw_err=0 next cycle. Issue 7 again with no writeback -> waw_err=1 for exactly one cycle.
- Write reg 9 = 32'h12345678 and issue reg 2, then assert rst for one cycle while wr_en=1 wr_sel=9 wr_data=32'hFFFFFFFF -> after the edge reg 9 reads 0 and pending=0.
- With REGFILE_R0_ZERO_EN defined, write 32'hFFFFFFFF to reg 0 and issue 0 -> rd_a_data=0 in the same and following cycles; pending[0]=0; waw_err=0.
